// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 16x-oversampling UART receiver: receiver state
// encoding, oversampling constants, sample points and the 2-of-3 vote helper
// used when the receiver is built with UART_RX_MAJORITY_EN.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int unsigned OVERSAMPLE = 16;

    // Single-sample decision points
    localparam logic [3:0] MID_TICK  = 4'd7;
    localparam logic [3:0] LAST_TICK = 4'd15;

    // Majority-vote sample points (decision taken at the last one)
    localparam logic [3:0] MAJ_TICK_A = 4'd7;
    localparam logic [3:0] MAJ_TICK_B = 4'd8;
    localparam logic [3:0] MAJ_TICK_C = 4'd9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous rx pin into the clk domain and flags its falling
// edges.  All flops preset to 1 (line idle) so reset never fakes a start edge.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   rx         raw serial line
//   rx_s       synchronized rx
//   fall_edge  one-clk pulse when rx_s goes 1 -> 0
// ---------------------------------------------------------------------------
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            rx_d   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_d   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign fall_edge = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx_16x.sv
// ---------------------------------------------------------------------------
// uart_rx_16x
// 8N1-style UART receiver (DATA_BITS data bits, LSB first) driven by a 16x
// baud clock-enable.  Optional build macro: UART_RX_MAJORITY_EN selects a
// 2-of-3 vote over ticks 7/8/9 of each bit instead of a single sample.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   baud_tick_16x   one-clk enable at 16x the baud rate
//   rx              asynchronous serial input, idles high
//   rx_data         last good word, held until the next good frame
//   rx_valid        one-clk pulse, rx_data is new
//   frame_err       one-clk pulse, stop bit sampled low
//   busy            high from start-edge detect until the frame ends
// ---------------------------------------------------------------------------
module uart_rx_16x #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick_16x,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int unsigned TICK_W   = $clog2(OVERSAMPLE);
    localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

    rx_state_e              state_q, state_d;
    logic                   rx_s, fall_edge;
    logic [TICK_W-1:0]      tick_cnt;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift_q;

    logic start_decide, bit_decide, bit_val;
    logic cnt_clr, bit_clr, shift_en, valid_set, err_set;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_s      (rx_s),
        .fall_edge (fall_edge)
    );

`ifdef UART_RX_MAJORITY_EN
    // The counter is never cleared after the start edge, so it stays aligned
    // to bit boundaries and ticks 7/8/9 straddle the centre of every bit.
    logic samp_a_q, samp_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_a_q <= 1'b1;
            samp_b_q <= 1'b1;
        end else if (baud_tick_16x) begin
            if (tick_cnt == MAJ_TICK_A) samp_a_q <= rx_s;
            if (tick_cnt == MAJ_TICK_B) samp_b_q <= rx_s;
        end
    end

    assign start_decide = baud_tick_16x && (tick_cnt == MAJ_TICK_C);
    assign bit_decide   = baud_tick_16x && (tick_cnt == MAJ_TICK_C);
    assign bit_val      = maj3(samp_a_q, samp_b_q, rx_s);
`else
    // Clearing at mid start bit re-bases the counter so tick 15 is mid-bit.
    assign start_decide = baud_tick_16x && (tick_cnt == MID_TICK);
    assign bit_decide   = baud_tick_16x && (tick_cnt == LAST_TICK);
    assign bit_val      = rx_s;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (fall_edge)    state_d = ST_START;
            ST_START: if (start_decide) state_d = bit_val ? ST_IDLE : ST_DATA;
            ST_DATA:  if (bit_decide && (bit_cnt == LAST_BIT)) state_d = ST_STOP;
            ST_STOP:  if (bit_decide)   state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Control outputs
    always_comb begin
        cnt_clr   = 1'b0;
        bit_clr   = 1'b0;
        shift_en  = 1'b0;
        valid_set = 1'b0;
        err_set   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Held at 0 here, so an edge coinciding with a tick starts at 0
                cnt_clr = 1'b1;
                bit_clr = 1'b1;
            end
            ST_START: begin
                bit_clr = 1'b1;
`ifndef UART_RX_MAJORITY_EN
                cnt_clr = start_decide;
`endif
            end
            ST_DATA:  shift_en = bit_decide;
            ST_STOP: begin
                valid_set = bit_decide & bit_val;
                err_set   = bit_decide & ~bit_val;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    // Counters, shift register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= valid_set;
            frame_err <= err_set;
            if (valid_set) rx_data <= shift_q;

            if (cnt_clr)            tick_cnt <= '0;
            else if (baud_tick_16x) tick_cnt <= tick_cnt + 1'b1;

            if (bit_clr)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 1'b1;

            if (shift_en) shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
        end
    end

endmodule

// File: doc/uart_rx_16x.md
Name: uart_rx_16x

Overview:
UART receiver consuming the 16x-oversampling tick produced by the team's baud generator.
- Converts the serial rx line into parallel bytes: 8N1 framing, LSB first.
- Everything runs on the single system clock; the 16x tick is a clock-enable, never a clock.
- Sits between the pad-side rx pin and the bridge logic, which consumes rx_data/rx_valid.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..9)
OVERSAMPLE, 16, ticks per bit period; fixed at 16 to match the baud generator
SYNC_STAGES, 2, flops in the rx input synchronizer (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
baud_tick_16x  input  1  one-clk-wide enable pulse at 16x baud rate, synchronous to clk
rx  input  1  asynchronous serial line; idles high
rx_data  output  DATA_BITS  last received word; held until the next good frame
rx_valid  output  1  one-clk pulse; rx_data is new
frame_err  output  1  one-clk pulse; stop bit sampled low
busy  output  1  high from start-bit detect until the frame ends

Behaviour:
- Reset (async assert, sync deassert by system): rx_data=0, rx_valid=0, frame_err=0, busy=0. State=IDLE, tick counter=0, bit counter=0. Synchronizer flops preset to 1.
- rx passes through SYNC_STAGES flops (rx_s). Falling-edge detect uses rx_s and its one-cycle delay.
- Tick counter (4 bits) advances only on clk cycles where baud_tick_16x=1. It wraps 15->0.
- IDLE:
  - On an rx_s falling edge: go to START, clear the tick counter, set busy=1.
  - An edge needs no tick to be detected.
- START:
  - At tick count 7 (mid start bit): if rx_s=0, go to DATA, clear the tick counter and bit counter.
  - If rx_s=1 at that point, treat it as a glitch: return to IDLE, busy=0, no pulse.
- DATA:
  - At tick count 15 (mid bit): shift rx_s into the MSB of a shift register (LSB-first framing).
  - After DATA_BITS samples, go to STOP with the tick counter cleared.
- STOP, at tick count 15:
  - If rx_s=1: rx_data<=shift register, rx_valid=1 for exactly one clk, go to IDLE, busy=0.
  - If rx_s=0: frame_err=1 for one clk, rx_data unchanged, go to IDLE, busy=0.
- After a frame error, IDLE still requires a fresh falling edge. A held-low (break) line therefore produces no further frames until it returns high.
- Latency: rx_valid/frame_err assert on the clk edge following the tick that samples the stop bit.
- Back-to-back frames: a start edge arriving in the same cycle rx_valid pulses is detected. No idle bit is required beyond the stop bit.
- No consumer handshake. An unread rx_data is overwritten by the next good frame (overrun is silent).
- A tick and an edge in the same cycle while IDLE: the edge wins, and the counter starts from 0.
- Reset mid-frame aborts immediately with no pulse. The next falling edge starts a clean frame.
- State encoding: IDLE=0, START=1, DATA=2, STOP=3.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit value (start, data, stop) is the 2-of-3 majority of rx_s captured at tick counts 7, 8, 9. Data and stop decisions move to tick 9. START validates at tick 9 using the same vote.
- Undefined: a single sample is taken, as described above.
- Port list is identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - the state enum/localparams;
  - OVERSAMPLE=16;
  - MID_TICK=7 and LAST_TICK=15;
  - the majority sample points 7/8/9.
- Natural sub-module: uart_rx_sync, which contains the SYNC_STAGES synchronizer plus falling-edge detect. Outputs: rx_s, fall_edge.
- The FSM, counters and shift register stay in uart_rx_16x.

Test Plan:
- Bench drives baud_tick_16x every 4 clk. Send 0xA5 with valid stop -> rx_data=0xA5, rx_valid high exactly 1 clk, frame_err=0, busy low afterwards.
- rx low for 4 ticks then high (glitch) -> no rx_valid, no frame_err, busy returns 0 at tick 7, rx_data keeps its prior value.
- Send 0x3C with stop bit driven low -> frame_err 1-clk pulse, rx_valid=0, rx_data unchanged. Hold rx low 40 bit-times -> no further pulses.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses carrying 0x00 then 0xFF, 160 ticks apart.
- Assert rst after 3 data bits of 0x77 -> all outputs 0 asynchronously. Release, send 0x5A -> rx_data=0x5A, rx_valid once.
- With UART_RX_MAJORITY_EN: invert rx for one tick at tick 8 of bit 2 of 0x0F -> rx_data=0x0F. Without the macro, same glitch at tick 15 -> bit 2 corrupted (0x0B).
